mac_pe_cfg: RTL and testbench

//  Parametrised systolic-array processing element: a registered multiply-accumulate cell

---
 rtl/mac_pe_cfg.sv | 143 ++++++++++++++
 tb/tb_mac_pe_cfg.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pe_cfg.sv
// Systolic-array MAC processing element with run-time OS/WS dataflow selection,
// double-buffered weight, saturating accumulator and daisy-chained result drain.
module mac_pe_cfg #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [DATA_W-1:0] left_in,
    input  logic              left_vld_in,
    input  logic [DATA_W-1:0] top_in,
    input  logic              top_vld_in,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              wt_load,
    input  logic              wt_swap,
    input  logic              acc_clr,
    input  logic              drain,
    output logic [DATA_W-1:0] right_out,
    output logic              right_vld_out,
    output logic [DATA_W-1:0] bottom_out,
    output logic              bottom_vld_out,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_vld_out,
    output logic              sat_flag
);

    localparam int PW = 2 * DATA_W;

    logic [DATA_W-1:0] left_q, top_q, wt_sh_q, wt_act_q;
    logic [DATA_W-1:0] wt_sh_d, wt_act_d;
    logic              left_vld_q, top_vld_q, drain_q;
    logic [ACC_W-1:0]  acc_q, acc_d, psum_q, psum_d;
    logic              psum_vld_q, psum_vld_d, sat_q, sat_d;

    logic [DATA_W-1:0] mult_b;
    logic [PW-1:0]     prod_s, prod_u;
    logic [ACC_W-1:0]  prod_ext;
    logic              fire, sat_set;
    logic [ACC_W:0]    os_sum, ws_sum;

    // Returns {overflow_clamped, sum}; the MSB flags a clamp event.
    function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        logic           ovf;
        s = {1'b0, a} + {1'b0, b};
        if (SIGNED != 0)
            ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
        else
            ovf = s[ACC_W];
        if (SATURATE == 0)
            ovf = 1'b0;
        if (ovf) begin
            if (SIGNED != 0)
                s[ACC_W-1:0] = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}};
            else
                s[ACC_W-1:0] = '1;
        end
        return {ovf, s[ACC_W-1:0]};
    endfunction

    assign mult_b = mode ? wt_act_q : top_q;
    assign prod_s = $signed({{DATA_W{left_q[DATA_W-1]}}, left_q})
                  * $signed({{DATA_W{mult_b[DATA_W-1]}}, mult_b});
    assign prod_u = {{DATA_W{1'b0}}, left_q} * {{DATA_W{1'b0}}, mult_b};

    always_comb begin
        prod_ext = ACC_W'(prod_u);
        if (SIGNED != 0)
            prod_ext = ACC_W'($signed(prod_s));
    end

    assign fire   = left_vld_q & top_vld_q;
    assign os_sum = add_sat(acc_q, prod_ext);
    assign ws_sum = add_sat(psum_in, left_vld_q ? prod_ext : '0);

    always_comb begin
        acc_d      = acc_q;
        psum_d     = psum_q;
        psum_vld_d = 1'b0;
        sat_set    = 1'b0;
        if (!mode) begin
            if (acc_clr) begin
                acc_d = fire ? prod_ext : '0;
            end else if (fire) begin
                acc_d   = os_sum[ACC_W-1:0];
                sat_set = os_sum[ACC_W];
            end
            // First drain cycle emits our own result, later ones pass the chain along.
            psum_vld_d = drain;
            if (drain)
                psum_d = drain_q ? psum_in : acc_q;
        end else begin
            psum_d     = ws_sum[ACC_W-1:0];
            psum_vld_d = left_vld_q;
            sat_set    = ws_sum[ACC_W];
        end
        sat_d    = acc_clr ? 1'b0 : (sat_q | sat_set);
        wt_sh_d  = wt_load ? top_in : wt_sh_q;
        wt_act_d = wt_swap ? wt_sh_q : wt_act_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_q     <= '0;
            left_vld_q <= 1'b0;
            top_q      <= '0;
            top_vld_q  <= 1'b0;
            wt_sh_q    <= '0;
            wt_act_q   <= '0;
            acc_q      <= '0;
            drain_q    <= 1'b0;
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            left_q     <= left_in;
            left_vld_q <= left_vld_in;
            top_q      <= top_in;
            top_vld_q  <= top_vld_in;
            wt_sh_q    <= wt_sh_d;
            wt_act_q   <= wt_act_d;
            acc_q      <= acc_d;
            drain_q    <= drain;
            psum_q     <= psum_d;
            psum_vld_q <= psum_vld_d;
            sat_q      <= sat_d;
        end
    end

    assign right_out      = left_q;
    assign right_vld_out  = left_vld_q;
    assign bottom_out     = top_q;
    assign bottom_vld_out = top_vld_q;
    assign psum_out       = psum_q;
    assign psum_vld_out   = psum_vld_q;
    assign sat_flag       = sat_q;

endmodule

// File: tb/tb_mac_pe_cfg.sv
// Bench for mac_pe_cfg: single PEs (24-bit sat, 16-bit sat, 16-bit wrap), a 4-PE
// weight column and a 3-PE drain row, checked against an arithmetic model.
module tb_mac_pe_cfg;
    localparam int DW = 8;
    localparam int AW = 24;
    localparam int AS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          mode, left_vld, top_vld, wt_load, wt_swap, acc_clr, drain;
    logic [DW-1:0] left_in, top_in;
    logic [AW-1:0] psum_in;

    logic [DW-1:0] d_right, d_bottom, s_right, s_bottom, w_right, w_bottom;
    logic          d_rvld, d_bvld, d_pvld, d_sat, s_rvld, s_bvld, s_pvld, s_sat;
    logic          w_rvld, w_bvld, w_pvld, w_sat;
    logic [AW-1:0] d_psum;
    logic [AS-1:0] s_psum, w_psum;

    int pass_cnt = 0;
    int total = 0;

    mac_pe_cfg #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .left_in(left_in), .left_vld_in(left_vld),
        .top_in(top_in), .top_vld_in(top_vld), .psum_in(psum_in), .wt_load(wt_load),
        .wt_swap(wt_swap), .acc_clr(acc_clr), .drain(drain), .right_out(d_right),
        .right_vld_out(d_rvld), .bottom_out(d_bottom), .bottom_vld_out(d_bvld),
        .psum_out(d_psum), .psum_vld_out(d_pvld), .sat_flag(d_sat));

    mac_pe_cfg #(.DATA_W(DW), .ACC_W(AS), .SIGNED(1), .SATURATE(1)) u_s16 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .left_in(left_in), .left_vld_in(left_vld),
        .top_in(top_in), .top_vld_in(top_vld), .psum_in(psum_in[AS-1:0]), .wt_load(wt_load),
        .wt_swap(wt_swap), .acc_clr(acc_clr), .drain(drain), .right_out(s_right),
        .right_vld_out(s_rvld), .bottom_out(s_bottom), .bottom_vld_out(s_bvld),
        .psum_out(s_psum), .psum_vld_out(s_pvld), .sat_flag(s_sat));

    mac_pe_cfg #(.DATA_W(DW), .ACC_W(AS), .SIGNED(1), .SATURATE(0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .left_in(left_in), .left_vld_in(left_vld),
        .top_in(top_in), .top_vld_in(top_vld), .psum_in(psum_in[AS-1:0]), .wt_load(wt_load),
        .wt_swap(wt_swap), .acc_clr(acc_clr), .drain(drain), .right_out(w_right),
        .right_vld_out(w_rvld), .bottom_out(w_bottom), .bottom_vld_out(w_bvld),
        .psum_out(w_psum), .psum_vld_out(w_pvld), .sat_flag(w_sat));

    // 4-PE column: weights shift down through bottom_out -> top_in
    logic [4:0][DW-1:0] c_top;
    logic [4:0]         c_tvld;
    logic [3:0][DW-1:0] c_right;
    logic [3:0]         c_rvld, c_pvld, c_sat;
    logic [3:0][AW-1:0] c_po;
    assign c_top[0]  = top_in;
    assign c_tvld[0] = top_vld;
    for (genvar g = 0; g < 4; g++) begin : g_col
        mac_pe_cfg #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SATURATE(1)) u_pe (
            .clk(clk), .rst_n(rst_n), .mode(mode), .left_in(left_in), .left_vld_in(left_vld),
            .top_in(c_top[g]), .top_vld_in(c_tvld[g]), .psum_in(psum_in), .wt_load(wt_load),
            .wt_swap(wt_swap), .acc_clr(acc_clr), .drain(drain), .right_out(c_right[g]),
            .right_vld_out(c_rvld[g]), .bottom_out(c_top[g+1]), .bottom_vld_out(c_tvld[g+1]),
            .psum_out(c_po[g]), .psum_vld_out(c_pvld[g]), .sat_flag(c_sat[g]));
    end

    // 3-PE row: operands shift right, psum chain head is PE0
    logic [2:0][DW-1:0] r_top;
    logic [3:0][DW-1:0] r_left;
    logic [3:0]         r_lvld;
    logic [3:0][AW-1:0] r_psum;
    logic [2:0][DW-1:0] r_bottom;
    logic [2:0]         r_bvld, r_pvld, r_sat;
    assign r_left[0] = left_in;
    assign r_lvld[0] = left_vld;
    assign r_psum[0] = psum_in;
    for (genvar g = 0; g < 3; g++) begin : g_row
        mac_pe_cfg #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SATURATE(1)) u_pe (
            .clk(clk), .rst_n(rst_n), .mode(mode), .left_in(r_left[g]), .left_vld_in(r_lvld[g]),
            .top_in(r_top[g]), .top_vld_in(top_vld), .psum_in(r_psum[g]), .wt_load(wt_load),
            .wt_swap(wt_swap), .acc_clr(acc_clr), .drain(drain), .right_out(r_left[g+1]),
            .right_vld_out(r_lvld[g+1]), .bottom_out(r_bottom[g]), .bottom_vld_out(r_bvld[g]),
            .psum_out(r_psum[g+1]), .psum_vld_out(r_pvld[g]), .sat_flag(r_sat[g]));
    end

    // ---------------- reference arithmetic ----------------
    function automatic longint sx(input longint v, input int w);
        longint m;
        m = longint'(1) << w;
        v = v & (m - 1);
        if (v >= m / 2) v = v - m;
        return v;
    endfunction

    function automatic longint sat_w(input longint v, input int w, output bit hit);
        longint mx, mn;
        mx  = (longint'(1) << (w - 1)) - 1;
        mn  = -mx - 1;
        hit = 1'b0;
        if (v > mx) begin hit = 1'b1; return mx; end
        if (v < mn) begin hit = 1'b1; return mn; end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        left_vld = 0; top_vld = 0; wt_load = 0; wt_swap = 0; acc_clr = 0; drain = 0;
        left_in = '0; top_in = '0; psum_in = '0; r_top = '0;
    endtask

    task automatic ws_probe();
        mode = 1; left_in = 8'd1; left_vld = 1; psum_in = '0;
        tick();
        left_vld = 0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        total++;
        if ({d_psum, d_pvld, d_sat, d_right, d_bottom, d_rvld, d_bvld} !== '0)
            $display("FAIL reset_dut got psum=%0h vld=%b sat=%b right=%0h", d_psum, d_pvld, d_sat, d_right);
        else pass_cnt++;
        total++;
        if ({s_psum, s_pvld, s_sat, c_po[3], r_psum[3]} !== '0)
            $display("FAIL reset_others got s_psum=%0h c3=%0h r3=%0h", s_psum, c_po[3], r_psum[3]);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total++;
        if ({d_psum, d_pvld, d_sat} !== '0)
            $display("FAIL post_reset_idle got psum=%0h vld=%b sat=%b exp 0", d_psum, d_pvld, d_sat);
        else pass_cnt++;
        // Active weight is 0 out of reset: WS passes psum_in unchanged.
        mode = 1; left_in = 8'd5; left_vld = 1;
        tick();
        left_vld = 0; psum_in = 24'd9;
        tick();
        total++;
        if (d_psum !== 24'd9 || d_pvld !== 1'b1)
            $display("FAIL reset_weight_zero got %0d vld=%b exp 9 vld=1", d_psum, d_pvld);
        else pass_cnt++;
        idle();
        tick();
    endtask

    task automatic test_os_basic();
        idle(); mode = 0; acc_clr = 1;
        tick();
        acc_clr = 0; left_vld = 1; top_vld = 1;
        left_in = 8'd3;   top_in = 8'd4; tick();
        left_in = 8'hFE;  top_in = 8'd5; tick();
        left_in = 8'd7;   top_in = 8'd7; tick();
        left_vld = 0; top_vld = 0;
        tick();
        drain = 1;
        tick();
        total++;
        if (d_psum !== 24'd51 || d_pvld !== 1'b1)
            $display("FAIL os_drain got %0d vld=%b exp 51 vld=1", d_psum, d_pvld);
        else pass_cnt++;
        drain = 0;
        tick();
        total++;
        if (d_pvld !== 1'b0) $display("FAIL os_drain_1cycle got vld=%b exp 0", d_pvld);
        else pass_cnt++;
    endtask

    task automatic test_ws_basic();
        idle(); mode = 1;
        top_in = 8'hFD; wt_load = 1; tick();
        wt_load = 0; wt_swap = 1; top_in = '0; tick();
        wt_swap = 0; left_in = 8'd10; left_vld = 1; tick();
        left_vld = 0; psum_in = 24'd100; tick();
        total++;
        if (d_psum !== 24'd70 || d_pvld !== 1'b1)
            $display("FAIL ws_mac got %0d vld=%b exp 70 vld=1", d_psum, d_pvld);
        else pass_cnt++;
        tick();
        total++;
        if (d_psum !== 24'd100 || d_pvld !== 1'b0)
            $display("FAIL ws_passthru got %0d vld=%b exp 100 vld=0", d_psum, d_pvld);
        else pass_cnt++;
        idle(); tick();
    endtask

    task automatic test_saturation();
        idle(); mode = 0; acc_clr = 1; tick();
        acc_clr = 0; left_in = 8'd127; top_in = 8'd127; left_vld = 1; top_vld = 1;
        repeat (3) tick();
        left_vld = 0; top_vld = 0; tick();
        drain = 1; tick(); drain = 0;
        total++;
        if (s_psum !== 16'h7FFF || s_sat !== 1'b1)
            $display("FAIL sat_clamp got %0h sat=%b exp 7fff sat=1", s_psum, s_sat);
        else pass_cnt++;
        total++;
        if (w_psum !== 16'hBD03 || w_sat !== 1'b0)
            $display("FAIL sat_wrap got %0h sat=%b exp bd03 sat=0", w_psum, w_sat);
        else pass_cnt++;
        total++;
        if (d_psum !== 24'd48387 || d_sat !== 1'b0)
            $display("FAIL sat_wide got %0d sat=%b exp 48387 sat=0", d_psum, d_sat);
        else pass_cnt++;
        tick(); tick();
        total++;
        if (s_sat !== 1'b1) $display("FAIL sat_sticky got %b exp 1", s_sat);
        else pass_cnt++;
        acc_clr = 1; tick(); acc_clr = 0;
        total++;
        if (s_sat !== 1'b0) $display("FAIL sat_clear got %b exp 0", s_sat);
        else pass_cnt++;
    endtask

    task automatic test_wt_chain();
        int exp_w [4] = '{44, 33, 22, 11};
        idle(); mode = 1;
        wt_load = 1;
        top_in = 8'd11; tick();
        top_in = 8'd22; tick();
        top_in = 8'd33; tick();
        top_in = 8'd44; tick();
        wt_load = 0; wt_swap = 1; top_in = '0; tick();
        wt_swap = 0;
        ws_probe();
        for (int g = 0; g < 4; g++) begin
            total++;
            if (sx(c_po[g], AW) !== longint'(exp_w[g]))
                $display("FAIL col_weight pe%0d got %0d exp %0d", g, sx(c_po[g], AW), exp_w[g]);
            else pass_cnt++;
        end
        top_in = 8'd66; wt_load = 1; tick();
        top_in = 8'd77; wt_swap = 1; tick();
        wt_load = 0; wt_swap = 0; top_in = '0;
        ws_probe();
        total++;
        if (d_psum !== 24'd66 || c_po[0] !== 24'd66)
            $display("FAIL load_swap_same got %0d/%0d exp 66", d_psum, c_po[0]);
        else pass_cnt++;
        wt_swap = 1; tick(); wt_swap = 0;
        ws_probe();
        total++;
        if (d_psum !== 24'd77) $display("FAIL swap_after got %0d exp 77", d_psum);
        else pass_cnt++;
        idle(); tick();
    endtask

    task automatic test_row_drain();
        int exp_t [3] = '{7, 6, 5};
        idle(); mode = 0;
        left_in = 8'd1; left_vld = 1; acc_clr = 1;
        repeat (4) tick();
        acc_clr = 0; r_top[0] = 8'd5; r_top[1] = 8'd6; r_top[2] = 8'd7; top_vld = 1;
        tick();
        top_vld = 0; tick();
        left_vld = 0; tick();
        drain = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (r_psum[3] !== 24'(exp_t[k]) || r_pvld[2] !== 1'b1)
                $display("FAIL row_drain[%0d] got %0d vld=%b exp %0d", k, r_psum[3], r_pvld[2], exp_t[k]);
            else pass_cnt++;
        end
        drain = 0; tick();
        total++;
        if (r_pvld[2] !== 1'b0) $display("FAIL row_drain_end got vld=%b exp 0", r_pvld[2]);
        else pass_cnt++;
    endtask

    task automatic test_random_os();
        longint ed, es, ew, p;
        bit sd, ss, hit;
        int n;
        for (int it = 0; it < 10; it++) begin
            ed = 0; es = 0; ew = 0; sd = 0; ss = 0;
            idle(); mode = 0; acc_clr = 1; tick(); acc_clr = 0;
            n = $urandom_range(3, 10);
            for (int k = 0; k < n; k++) begin
                left_in = 8'($urandom); top_in = 8'($urandom);
                left_vld = ($urandom_range(0, 3) != 0); top_vld = ($urandom_range(0, 3) != 0);
                if (left_vld && top_vld) begin
                    p  = sx(left_in, DW) * sx(top_in, DW);
                    ed = sat_w(ed + p, AW, hit); sd |= hit;
                    es = sat_w(es + p, AS, hit); ss |= hit;
                    ew = sx(ew + p, AS);
                end
                tick();
                total++;
                if (d_right !== left_in || d_bottom !== top_in || d_rvld !== left_vld)
                    $display("FAIL fwd got r=%0h b=%0h exp r=%0h b=%0h", d_right, d_bottom, left_in, top_in);
                else pass_cnt++;
            end
            left_vld = 0; top_vld = 0; tick();
            drain = 1; tick(); drain = 0;
            total++;
            if (sx(d_psum, AW) !== ed || d_sat !== sd)
                $display("FAIL rnd_os24 it%0d got %0d sat=%b exp %0d sat=%b", it, sx(d_psum, AW), d_sat, ed, sd);
            else pass_cnt++;
            total++;
            if (sx(s_psum, AS) !== es || s_sat !== ss)
                $display("FAIL rnd_os16s it%0d got %0d sat=%b exp %0d sat=%b", it, sx(s_psum, AS), s_sat, es, ss);
            else pass_cnt++;
            total++;
            if (sx(w_psum, AS) !== ew || w_sat !== 1'b0)
                $display("FAIL rnd_os16w it%0d got %0d sat=%b exp %0d sat=0", it, sx(w_psum, AS), w_sat, ew);
            else pass_cnt++;
        end
    endtask

    task automatic test_random_ws();
        longint ed, es, ew, p, wt;
        bit sd, ss, hit, prev_v;
        logic [DW-1:0] prev_l;
        idle(); mode = 1;
        top_in = 8'($urandom); wt = sx(top_in, DW);
        wt_load = 1; tick();
        wt_load = 0; wt_swap = 1; tick();
        wt_swap = 0; acc_clr = 1; tick(); acc_clr = 0;
        sd = 0; ss = 0; prev_v = 0; prev_l = '0;
        for (int k = 0; k < 24; k++) begin
            left_in = 8'($urandom); left_vld = $urandom_range(0, 1) != 0; psum_in = 24'($urandom);
            tick();
            p  = prev_v ? sx(prev_l, DW) * wt : 0;
            ed = sat_w(sx(psum_in, AW) + p, AW, hit); sd |= hit;
            es = sat_w(sx(psum_in, AS) + p, AS, hit); ss |= hit;
            ew = sx(sx(psum_in, AS) + p, AS);
            total++;
            if (sx(d_psum, AW) !== ed || d_pvld !== prev_v)
                $display("FAIL rnd_ws24 k%0d got %0d vld=%b exp %0d vld=%b", k, sx(d_psum, AW), d_pvld, ed, prev_v);
            else pass_cnt++;
            total++;
            if (sx(s_psum, AS) !== es || sx(w_psum, AS) !== ew)
                $display("FAIL rnd_ws16 k%0d got s=%0d w=%0d exp s=%0d w=%0d", k, sx(s_psum, AS), sx(w_psum, AS), es, ew);
            else pass_cnt++;
            prev_v = left_vld; prev_l = left_in;
        end
        total++;
        if (d_sat !== sd || s_sat !== ss || w_sat !== 1'b0)
            $display("FAIL rnd_ws_sat got %b%b%b exp %b%b0", d_sat, s_sat, w_sat, sd, ss);
        else pass_cnt++;
        idle(); tick();
    endtask

    task automatic test_reset_mid();
        idle(); mode = 0; acc_clr = 1; tick();
        acc_clr = 0; left_in = 8'd127; top_in = 8'd127; left_vld = 1; top_vld = 1;
        repeat (3) tick();
        left_vld = 0; top_vld = 0; tick();
        drain = 1; tick();
        total++;
        if (s_pvld !== 1'b1 || s_sat !== 1'b1)
            $display("FAIL pre_reset got vld=%b sat=%b exp 1 1", s_pvld, s_sat);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({d_psum, d_pvld, d_sat, d_right, d_bottom, d_rvld, d_bvld} !== '0)
            $display("FAIL mid_reset_dut got psum=%0h vld=%b", d_psum, d_pvld);
        else pass_cnt++;
        total++;
        if ({s_psum, s_pvld, s_sat, r_psum[3], c_po[0]} !== '0)
            $display("FAIL mid_reset_others got s=%0h vld=%b sat=%b", s_psum, s_pvld, s_sat);
        else pass_cnt++;
        idle();
        tick();
        #2 rst_n = 1'b1;
        tick();
        left_vld = 1; top_vld = 1;
        left_in = 8'd2; top_in = 8'd3; tick();
        left_in = 8'd5; top_in = 8'd6; tick();
        left_vld = 0; top_vld = 0; acc_clr = 1; tick();
        acc_clr = 0; tick();
        drain = 1; tick(); drain = 0;
        total++;
        if (d_psum !== 24'd30 || s_psum !== 16'd30)
            $display("FAIL clr_fire got %0d/%0d exp 30", d_psum, s_psum);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        mode = 0;
        idle();
        test_reset();
        test_os_basic();
        test_ws_basic();
        test_saturation();
        test_wt_chain();
        test_row_drain();
        test_random_os();
        test_random_ws();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
